// File: rtl/sort_pkg.sv
// Shared sizing, FSM state type and mask helper for the min_sort bit-serial sorter.
package sort_pkg;
  localparam int M     = 4;
  localparam int KEY_W = 4;
  localparam int IDX_W = $clog2(M);
  localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic logic onehot(input logic [M-1:0] v);
    return (v != '0) && ((v & (v - M'(1))) == '0);
  endfunction
endpackage

// File: rtl/min_sort_pick.sv
// Lowest-set-bit priority selector: one-hot select plus its binary row index.
module min_sort_pick
  import sort_pkg::*;
(
  input  logic [M-1:0]     mask_i,
  output logic [M-1:0]     sel_o,
  output logic [IDX_W-1:0] idx_o
);
  assign sel_o = mask_i & (~mask_i + M'(1));

  always_comb begin
    idx_o = '0;
    for (int k = M - 1; k >= 0; k--)
      if (mask_i[k]) idx_o = IDX_W'(k);
  end
endmodule

// File: rtl/min_sort_ctrl.sv
// Bit-serial minimum-extraction sequencer: MSB-first plane scan, stable ascending emit.
// Optional MIN_SORT_EARLY_EXIT_EN leaves SCAN as soon as a single candidate remains.
module min_sort_ctrl
  import sort_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [M-1:0][KEY_W-1:0]   i_keys,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [IDX_W-1:0]          o_idx,
  output logic [KEY_W-1:0]          o_key,
  output logic                      o_last,
  output logic                      o_busy
);
  state_e                   state_q, state_d;
  logic [M-1:0][KEY_W-1:0]  key_q, key_d;
  logic [M-1:0]             alive_q, alive_d;
  logic [M-1:0]             cand_q, cand_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [M-1:0]             sel_q;
  logic [IDX_W-1:0]         idx_q;
  logic [KEY_W-1:0]         okey_q;
  logic                     last_q;

  logic [M-1:0]             plane, zeros, scan_cand, rest, pick_sel;
  logic [IDX_W-1:0]         pick_idx;
  logic                     early, emit_ld;

  for (genvar k = 0; k < M; k++) begin : g_plane
    assign plane[k] = key_q[k][cnt_q];
  end

  assign zeros     = cand_q & ~plane;
  assign scan_cand = (zeros != '0) ? zeros : cand_q;
  assign rest      = alive_q & ~sel_q;

`ifdef MIN_SORT_EARLY_EXIT_EN
  assign early = onehot(scan_cand);
`else
  assign early = 1'b0;
`endif

  // Picking from the next cand lets the emit outputs be registered on EMIT entry.
  min_sort_pick u_pick (
    .mask_i (scan_cand),
    .sel_o  (pick_sel),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    alive_d = alive_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit_ld = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        key_d   = i_keys;
        alive_d = '1;
        cand_d  = '1;
        cnt_d   = CNT_W'(KEY_W - 1);
        state_d = SCAN;
      end
      SCAN: begin
        cand_d = scan_cand;
        if (cnt_q == '0 || early) begin
          state_d = EMIT;
          emit_ld = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EMIT: if (i_ready) begin
        alive_d = rest;
        if (rest == '0) begin
          state_d = IDLE;
        end else begin
          cand_d  = rest;
          cnt_d   = CNT_W'(KEY_W - 1);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      alive_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      okey_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      alive_q <= alive_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      if (emit_ld) begin
        sel_q  <= pick_sel;
        idx_q  <= pick_idx;
        okey_q <= key_q[pick_idx];
        last_q <= ($countones(alive_q) == 1);
      end
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == EMIT);
  assign o_busy  = (state_q != IDLE);
  assign o_idx   = idx_q;
  assign o_key   = okey_q;
  assign o_last  = last_q;
endmodule

// File: tb/tb_min_sort_ctrl.sv
// Randomized self-checking bench for min_sort_ctrl against a sort-based reference model.
module tb_min_sort_ctrl;
  import sort_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [M-1:0][KEY_W-1:0]  keys;
  logic                     in_vld, out_rdy;
  logic                     rdy, vld, last, busy;
  logic [IDX_W-1:0]         idx;
  logic [KEY_W-1:0]         key;

  int total = 0;
  int bad   = 0;
  int first_cyc, last_hs, last_gap;

  always #5 clk = ~clk;

  min_sort_ctrl dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_keys  (keys),
    .i_valid (in_vld),
    .o_ready (rdy),
    .o_valid (vld),
    .i_ready (out_rdy),
    .o_idx   (idx),
    .o_key   (key),
    .o_last  (last),
    .o_busy  (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0][KEY_W-1:0] mk4(input int a, b, c, d);
    logic [M-1:0][KEY_W-1:0] v;
    v = '0;
    v[0] = KEY_W'(a); v[1] = KEY_W'(b); v[2] = KEY_W'(c); v[3] = KEY_W'(d);
    return v;
  endfunction

  function automatic logic [M-1:0][KEY_W-1:0] rnd_keys();
    logic [M-1:0][KEY_W-1:0] v;
    for (int i = 0; i < M; i++) v[i] = KEY_W'($urandom);
    return v;
  endfunction

  // mode: 0 ready high, 1 ready toggling, 2 ready random
  task automatic run_frame(input logic [M-1:0][KEY_W-1:0] k, input int mode, input bit hold_vld);
    int q[$];
    int n, cyc, guard, prev_hs;
    bit held, seen;
    logic [IDX_W-1:0] p_idx;
    logic [KEY_W-1:0] p_key;
    logic p_last;
    for (int i = 0; i < M; i++) q.push_back(int'(k[i]) * M + i);
    q.sort();
    guard = 0;
    while (rdy !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_rdy", rdy, 1);
    keys = k; in_vld = 1'b1; out_rdy = 1'b0;
    cyc = 0; n = 0; held = 0; seen = 0; prev_hs = 0;
    p_idx = '0; p_key = '0; p_last = 1'b0;
    while (n < M && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold_vld) in_vld = 1'b0;
      keys = rnd_keys();
      out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      chk("busy_rdy", {busy, rdy}, 2'b10);
      if (held) begin
        chk("hold_idx", idx, p_idx);
        chk("hold_key", key, p_key);
        chk("hold_last", last, p_last);
      end
      if (vld) begin
        if (!seen) begin seen = 1; first_cyc = cyc; end
        if (out_rdy) begin
          chk("idx", idx, q[n] % M);
          chk("key", key, q[n] / M);
          chk("last", last, n == M - 1);
          if (n == M - 1) begin
            last_gap = cyc - prev_hs;
            last_hs  = cyc;
            in_vld   = 1'b0;
          end
          prev_hs = cyc;
          n++;
        end
      end
      held = vld && !out_rdy;
      p_idx = idx; p_key = key; p_last = last;
    end
    if (n < M) chk("timeout", n, M);
    @(negedge clk);
    out_rdy = 1'b0;
    chk("rdy_after", {busy, rdy, vld}, 3'b010);
  endtask

  initial begin
    int guard;
    rst = 1'b1; keys = '0; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {rdy, vld, last, busy}, 4'b1000);
    chk("rst_idx", idx, 0);
    chk("rst_key", key, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(mk4(5, 2, 9, 2), 0, 0);
`ifndef MIN_SORT_EARLY_EXIT_EN
    chk("first_vld", first_cyc, KEY_W + 1);
    chk("frame_len", last_hs, M * (KEY_W + 1));
`endif
    run_frame(mk4(15, 15, 15, 15), 0, 0);
`ifndef MIN_SORT_EARLY_EXIT_EN
    chk("frame_len15", last_hs, M * (KEY_W + 1));
`endif
    run_frame(mk4(5, 2, 9, 2), 1, 0);

    // abort during the second element's scan
    keys = mk4(5, 2, 9, 2); in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    guard = 0;
    while (vld !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_first_vld", vld, 1);
    @(negedge clk);
    chk("rst_in_scan", vld, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", {vld, busy, rdy}, 3'b001);
    rst = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("rst_quiet", {vld, busy}, 2'b00);
    run_frame(mk4(0, 1, 2, 3), 0, 0);

    run_frame(mk4(5, 2, 9, 2), 2, 1);

`ifdef MIN_SORT_EARLY_EXIT_EN
    run_frame(mk4(8, 0, 4, 12), 0, 0);
    chk("ee_first", first_cyc, 3);
    chk("ee_last_gap", last_gap, 2);
`endif

    for (int t = 0; t < 8; t++) begin
      run_frame(rnd_keys(), t % 3, t[0]);
`ifndef MIN_SORT_EARLY_EXIT_EN
      chk("rnd_first", first_cyc, KEY_W + 1);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
